// File: rtl/ncl_rx_pkg.sv
// Shared types and constants for the NCL-to-synchronous receiver.
// Rail pairs are {rail1, rail0} per digit.
package ncl_rx_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic [1:0] RAIL_NULL    = 2'b00;
    localparam logic [1:0] RAIL_DATA0   = 2'b01;
    localparam logic [1:0] RAIL_DATA1   = 2'b10;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        RESYNC    = 2'd0,
        WAIT_DATA = 2'd1,
        WAIT_NULL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/ncl_digit_sync.sv
// One dual-rail digit: two-flop synchronizer on both rails plus
// NULL / DATA / ILLEGAL classification of the synchronized pair.
module ncl_digit_sync
    import ncl_rx_pkg::*;
(
    input  logic       clk,
    input  logic       init_n,
    input  logic [1:0] rails,
    output logic [1:0] rails_sync,
    output logic       is_null,
    output logic       is_data,
    output logic       is_illegal
);

    logic [1:0] meta;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            meta       <= '0;
            rails_sync <= '0;
        end else begin
            meta       <= rails;
            rails_sync <= meta;
        end
    end

    always_comb begin
        is_null    = (rails_sync == RAIL_NULL);
        is_data    = (rails_sync == RAIL_DATA0) || (rails_sync == RAIL_DATA1);
        is_illegal = (rails_sync == RAIL_ILLEGAL);
    end

endmodule

// File: rtl/ncl_sync_receiver.sv
// Receives NCL dual-rail wavefronts into the clk domain, hands each DATA
// word to a valid/ready consumer and returns completion (ack) to the sender.
module ncl_sync_receiver
    import ncl_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic [2*WIDTH-1:0] dr_data,
    output logic               ack,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err,
    output logic [CNT_W-1:0]   wave_cnt
);

    logic [2*WIDTH-1:0] rails_s;
    logic [2*WIDTH-1:0] rails_q;
    logic [WIDTH-1:0]   dig_null;
    logic [WIDTH-1:0]   dig_data;
    logic [WIDTH-1:0]   dig_ill;
    logic [WIDTH-1:0]   word_s;
    logic               complete;
    logic               empty;
    logic               bad_wave;
    logic               capture;
    logic [1:0]         primed;
    rx_state_e          state;
    rx_state_e          state_nx;

    for (genvar k = 0; k < WIDTH; k++) begin : g_digit
        ncl_digit_sync u_sync (
            .clk        (clk),
            .init_n     (init_n),
            .rails      (dr_data[2*k+1:2*k]),
            .rails_sync (rails_s[2*k+1:2*k]),
            .is_null    (dig_null[k]),
            .is_data    (dig_data[k]),
            .is_illegal (dig_ill[k])
        );
    end

    always_comb begin
        word_s = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            word_s[k] = rails_s[2*k+1];
        end
        complete = &dig_data;
        empty    = &dig_null;
        bad_wave = (|dig_ill)
                 || ((state == WAIT_DATA) && (|(rails_q & ~rails_s)))
                 || ((state == WAIT_NULL) && (|(~rails_q & rails_s)));
    end

    // The synchronizer resets to all-NULL, which is not a real observation of
    // dr_data; RESYNC only trusts EMPTY once both sync stages have refilled.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        ack      = (state == WAIT_NULL);
        case (state)
            RESYNC: begin
                if (empty && primed[1]) state_nx = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (complete && (!out_valid || out_ready)) begin
                    capture  = 1'b1;
                    state_nx = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (empty) state_nx = WAIT_DATA;
            end
            default: state_nx = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state <= RESYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            primed    <= '0;
            rails_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            wave_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            primed  <= {primed[0], 1'b1};
            rails_q <= rails_s;
            if (capture) begin
                out_data  <= word_s;
                out_valid <= 1'b1;
                wave_cnt  <= wave_cnt + CNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (bad_wave) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ncl_sync_receiver.sv
// Directed bench for ncl_sync_receiver at WIDTH=4, CNT_W=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ncl_sync_receiver;

    logic       clk;
    logic       init_n;
    logic [7:0] dr_data;
    logic       ack;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [3:0] wave_cnt;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned cnt_exp;

    ncl_sync_receiver #(
        .WIDTH (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .dr_data   (dr_data),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .wave_cnt  (wave_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] enc(input logic [3:0] v);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[2*k +: 2] = v[k] ? 2'b10 : 2'b01;
        return r;
    endfunction

    // Present a DATA wavefront, confirm ack rises on exactly the 3rd edge.
    task automatic send_data(input string tag, input logic [3:0] v);
        dr_data = enc(v);
        step(2);
        check({tag, "_ack_early"}, 32'(ack), 0);
        step(1);
        check({tag, "_ack"}, 32'(ack), 1);
        check({tag, "_data"}, 32'(out_data), 32'(v));
    endtask

    task automatic send_null(input string tag);
        dr_data = '0;
        step(2);
        check({tag, "_ack_hold"}, 32'(ack), 1);
        step(1);
        check({tag, "_ack_fall"}, 32'(ack), 0);
    endtask

    task automatic do_reset(input logic [7:0] rails);
        @(negedge clk);
        init_n  = 1'b0;
        dr_data = rails;
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", 32'(wave_cnt), 0);
        step(2);
        init_n = 1'b1;
        cnt_exp = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cnt_exp   = 0;
        init_n    = 1'b0;
        dr_data   = '0;
        out_ready = 1'b1;

        // Basic wavefront 0x5, out_valid pulses for one cycle
        do_reset(8'h00);
        step(4);
        send_data("w5", 4'h5);
        cnt_exp++;
        check("w5_valid", 32'(out_valid), 1);
        check("w5_cnt", 32'(wave_cnt), cnt_exp);
        step(1);
        check("w5_valid_pulse", 32'(out_valid), 0);
        send_null("w5");

        // Skewed arrival, one digit per cycle, value 0x9
        begin
            logic [7:0] full;
            logic [7:0] part;
            full = enc(4'h9);
            part = '0;
            for (int k = 0; k < 4; k++) begin
                part[2*k +: 2] = full[2*k +: 2];
                dr_data = part;
                step(1);
                check("skew_ack_partial", 32'(ack), 0);
            end
            step(1);
            check("skew_ack_lastsync", 32'(ack), 0);
            step(1);
            check("skew_ack", 32'(ack), 1);
            check("skew_data", 32'(out_data), 32'h9);
            check("skew_err", 32'(err), 0);
            cnt_exp++;
        end
        send_null("skew");

        // Backpressure: 0x3 held, 0xC waits for out_ready
        out_ready = 1'b0;
        send_data("bp3", 4'h3);
        cnt_exp++;
        send_null("bp3");
        dr_data = enc(4'hC);
        step(5);
        check("bp_ack_held", 32'(ack), 0);
        check("bp_data_held", 32'(out_data), 32'h3);
        check("bp_valid_held", 32'(out_valid), 1);
        out_ready = 1'b1;
        step(1);
        cnt_exp++;
        check("bpC_ack", 32'(ack), 1);
        check("bpC_data", 32'(out_data), 32'hC);
        check("bpC_valid", 32'(out_valid), 1);
        check("bpC_cnt", 32'(wave_cnt), cnt_exp);
        step(1);
        check("bpC_valid_clr", 32'(out_valid), 0);
        send_null("bpC");

        // Reset released with stale DATA 0xF on the rails
        do_reset(enc(4'hF));
        step(5);
        check("stale_ack", 32'(ack), 0);
        check("stale_valid", 32'(out_valid), 0);
        check("stale_cnt", 32'(wave_cnt), 0);
        dr_data = '0;
        step(3);
        send_data("stA", 4'hA);
        cnt_exp++;
        check("stA_cnt", 32'(wave_cnt), cnt_exp);
        check("stA_err", 32'(err), 0);
        send_null("stA");

        // Illegal digit 2 in WAIT_DATA sets sticky err, FSM unaffected
        dr_data = 8'b00_11_00_00;
        step(3);
        check("ill_err", 32'(err), 1);
        check("ill_ack", 32'(ack), 0);
        dr_data = '0;
        step(3);
        check("ill_err_sticky", 32'(err), 1);
        send_data("ill6", 4'h6);
        cnt_exp++;
        check("ill6_cnt", 32'(wave_cnt), cnt_exp);
        send_null("ill6");
        check("ill6_err_sticky", 32'(err), 1);

        // 17 wavefronts wrap the 4-bit counter to 1
        do_reset(8'h00);
        step(3);
        for (int i = 0; i < 17; i++) begin
            send_data("wrap", 4'(i));
            cnt_exp = (cnt_exp + 1) % 16;
            check("wrap_cnt", 32'(wave_cnt), cnt_exp);
            send_null("wrap");
        end
        check("wrap_final_cnt", 32'(wave_cnt), 1);
        check("wrap_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
